count_rx: RTL and testbench

COUNT_RX -- requirements
Module: count_rx

---
 rtl/count_pkg.sv | 5 +
 rtl/count_rx_if.sv | 8 +
 rtl/count_hold.sv | 27 ++
 rtl/count_rx.sv | 80 ++++++++
 tb/tb_count_rx.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/count_pkg.sv
// count_pkg: shared receiver state encoding and default word width
package count_pkg;
   localparam int DEFAULT_WIDTH = 16;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/count_rx_if.sv
// count_rx_if: valid/ready word handoff from the receiver to its consumer
interface count_rx_if import count_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) ();
   logic [WIDTH-1:0] count;
   logic             count_valid;
   logic             count_ready;
   modport master(output count, count_valid, input count_ready);
   modport slave(input count, count_valid, output count_ready);
endinterface

// File: rtl/count_hold.sv
// count_hold: single-entry output holding register with valid/ready and overrun pulse
module count_hold import count_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] word,
   count_rx_if.master       bus,
   output logic             overrun
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.count       <= '0;
         bus.count_valid <= 1'b0;
         overrun         <= 1'b0;
      end else begin
         overrun <= load & bus.count_valid & ~bus.count_ready;
         if (load && (!bus.count_valid || bus.count_ready)) begin
            bus.count       <= word;
            bus.count_valid <= 1'b1;
         end else if (bus.count_ready) begin
            bus.count_valid <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/count_rx.sv
// count_rx: strobed serial frame receiver (start, LSB-first data, optional even parity, stop)
module count_rx import count_pkg::*; #(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sin,
   input  logic       sin_en,
   count_rx_if.master bus,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun
);
   localparam int CW = $clog2(WIDTH);
   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [CW-1:0]    bit_cnt, bit_cnt_n;
   logic             par_bad, par_bad_n;
   logic             good, ferr, perr;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         par_bad    <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         state      <= state_n;
         shreg      <= shreg_n;
         bit_cnt    <= bit_cnt_n;
         par_bad    <= par_bad_n;
         frame_err  <= ferr;
         parity_err <= perr;
      end
   end
   // every transition is gated by the bit strobe; stop-bit outcome is decoded here
   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      par_bad_n = par_bad;
      good      = 1'b0;
      ferr      = 1'b0;
      perr      = 1'b0;
      if (sin_en) begin
         case (state)
            IDLE: begin
               state_n   = sin ? IDLE : DATA;
               bit_cnt_n = '0;
               par_bad_n = 1'b0;
            end
            DATA: begin
               shreg_n   = {sin, shreg[WIDTH-1:1]};
               bit_cnt_n = bit_cnt + 1'b1;
               state_n   = (bit_cnt == CW'(WIDTH-1)) ? (PARITY_EN ? PARITY : STOP) : DATA;
            end
            PARITY: begin
               par_bad_n = ^shreg ^ sin;
               state_n   = STOP;
            end
            default: begin
               state_n = IDLE;
               ferr    = ~sin;
               perr    = sin & par_bad;
               good    = sin & ~par_bad;
            end
         endcase
      end
   end
   count_hold #(.WIDTH(WIDTH)) u_hold (
      .clk     (clk),
      .rst     (rst),
      .load    (good),
      .word    (shreg),
      .bus     (bus),
      .overrun (overrun)
   );
endmodule

// File: tb/tb_count_rx.sv
// tb_count_rx: directed frame vectors against count_rx with hand-computed expectations
module tb_count_rx;
   logic        clk = 1'b0, rst = 1'b1, sin = 1'b1, sin_en = 1'b0;
   logic        frame_err, parity_err, overrun;
   int          n_checks = 0, n_errors = 0;
   int          n_fe = 0, n_pe = 0, n_ov = 0, n_xfer = 0;
   int          b_fe, b_pe, b_ov, b_xfer;
   logic [15:0] last_word = '0;
   count_rx_if #(.WIDTH(16)) bus ();
   count_rx #(.WIDTH(16), .PARITY_EN(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .sin        (sin),
      .sin_en     (sin_en),
      .bus        (bus),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (frame_err === 1'b1) n_fe <= n_fe + 1;
      if (parity_err === 1'b1) n_pe <= n_pe + 1;
      if (overrun === 1'b1) n_ov <= n_ov + 1;
      if (bus.count_valid === 1'b1 && bus.count_ready === 1'b1) begin
         n_xfer    <= n_xfer + 1;
         last_word <= bus.count;
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic snap();
      b_fe = n_fe; b_pe = n_pe; b_ov = n_ov; b_xfer = n_xfer;
   endtask
   task automatic bit_out(input logic b, input int per);
      repeat (per - 1) begin
         @(posedge clk); #1;
         sin_en = 1'b0;
         sin = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      sin = b;
      sin_en = 1'b1;
   endtask
   task automatic frame(input logic [15:0] d, input logic p, input logic s, input int per);
      bit_out(1'b0, per);
      for (int i = 0; i < 16; i++) bit_out(d[i], per);
      bit_out(p, per);
      bit_out(s, per);
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         sin = 1'b1;
         sin_en = 1'b1;
      end
   endtask
   initial begin
      bus.count_ready = 1'b1;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_count", 32'(bus.count), 32'h0);
      check("rst_valid", 32'(bus.count_valid), 32'h0);
      check("rst_pulses", 32'({frame_err, parity_err, overrun}), 32'h0);
      rst = 1'b1;
      idle(2);
      snap();
      frame(16'hA5C3, 1'b0, 1'b1, 1);
      idle(1);
      check("good_valid", 32'(bus.count_valid), 32'h1);
      check("good_count", 32'(bus.count), 32'hA5C3);
      idle(3);
      check("good_xfer", 32'(n_xfer - b_xfer), 32'd1);
      check("good_word", 32'(last_word), 32'hA5C3);
      check("good_errs", 32'(n_fe - b_fe + n_pe - b_pe + n_ov - b_ov), 32'd0);
      snap();
      frame(16'hA5C3, 1'b1, 1'b1, 1);
      idle(1);
      check("par_pulse_now", 32'(parity_err), 32'h1);
      check("par_valid", 32'(bus.count_valid), 32'h0);
      idle(3);
      check("par_pulses", 32'(n_pe - b_pe), 32'd1);
      check("par_fe", 32'(n_fe - b_fe), 32'd0);
      check("par_xfer", 32'(n_xfer - b_xfer), 32'd0);
      snap();
      frame(16'hA5C3, 1'b1, 1'b0, 1);
      frame(16'h0001, 1'b1, 1'b1, 1);
      idle(1);
      check("fe_next_valid", 32'(bus.count_valid), 32'h1);
      check("fe_next_count", 32'(bus.count), 32'h0001);
      idle(3);
      check("fe_pulses", 32'(n_fe - b_fe), 32'd1);
      check("fe_no_pe", 32'(n_pe - b_pe), 32'd0);
      check("fe_xfer", 32'(n_xfer - b_xfer), 32'd1);
      bus.count_ready = 1'b0;
      snap();
      frame(16'h1234, 1'b1, 1'b1, 1);
      frame(16'h5678, 1'b0, 1'b1, 1);
      idle(3);
      check("ov_count", 32'(bus.count), 32'h1234);
      check("ov_valid", 32'(bus.count_valid), 32'h1);
      check("ov_pulses", 32'(n_ov - b_ov), 32'd1);
      check("ov_no_xfer", 32'(n_xfer - b_xfer), 32'd0);
      bus.count_ready = 1'b1;
      idle(3);
      check("ov_xfer", 32'(n_xfer - b_xfer), 32'd1);
      check("ov_word", 32'(last_word), 32'h1234);
      check("ov_drained", 32'(bus.count_valid), 32'h0);
      snap();
      frame(16'hFFFF, 1'b0, 1'b1, 4);
      idle(1);
      check("slow_count", 32'(bus.count), 32'hFFFF);
      idle(3);
      check("slow_xfer", 32'(n_xfer - b_xfer), 32'd1);
      check("slow_errs", 32'(n_fe - b_fe + n_pe - b_pe + n_ov - b_ov), 32'd0);
      snap();
      bit_out(1'b0, 1);
      for (int i = 0; i < 8; i++) bit_out(1'b1, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      sin = 1'b1;
      idle(2);
      check("mid_rst_count", 32'(bus.count), 32'h0);
      check("mid_rst_valid", 32'(bus.count_valid), 32'h0);
      rst = 1'b1;
      idle(2);
      frame(16'h00FF, 1'b0, 1'b1, 1);
      idle(4);
      check("rst_frame_xfer", 32'(n_xfer - b_xfer), 32'd1);
      check("rst_frame_word", 32'(last_word), 32'h00FF);
      check("rst_frame_errs", 32'(n_fe - b_fe + n_pe - b_pe + n_ov - b_ov), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
